// File: rtl/lsu_ctrl.sv
// Load/store initiator between execute and datamem.
// Word-crossing accesses are split into two memory cycles.
module lsu_ctrl #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1,
    S_RESP
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic [31:0] r_lo;
  logic        r_rvalid;
  logic        r_rerr;
  logic [31:0] r_rdata;
  logic        r_mem_we;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_a;
  logic [31:0] r_mem_wd;

  logic        w_idle;
  logic        w_we;
  logic [2:0]  w_f3;
  logic [1:0]  w_off;
  logic [31:0] w_wdata;
  logic [2:0]  w_size;
  logic [7:0]  w_base;
  logic [7:0]  w_mask;
  logic [63:0] w_wd64;
  logic        w_legal;
  logic        w_misal;
  logic        w_err;
  logic        w_cross;

  function automatic logic [31:0] f_load(
    input logic [2:0]  f3,
    input logic [1:0]  off,
    input logic [63:0] dw
  );
    logic [31:0] s;
    s = 32'(dw >> {off, 3'b000});
    unique case (f3)
      3'b000:  f_load = {{24{s[7]}}, s[7:0]};
      3'b001:  f_load = {{16{s[15]}}, s[15:0]};
      3'b100:  f_load = {24'b0, s[7:0]};
      3'b101:  f_load = {16'b0, s[15:0]};
      default: f_load = s;
    endcase
  endfunction

  // Decode from live request inputs while idle, from latched copy afterwards.
  always_comb begin
    w_idle  = (r_state == S_IDLE);
    w_we    = w_idle ? req_we : r_we;
    w_f3    = w_idle ? req_funct3 : r_f3;
    w_off   = w_idle ? req_addr[1:0] : r_off;
    w_wdata = w_idle ? req_wdata : r_wdata;
    w_size  = 3'd4;
    w_base  = 8'h0f;
    unique case (w_f3[1:0])
      2'b00: begin
        w_size = 3'd1;
        w_base = 8'h01;
      end
      2'b01: begin
        w_size = 3'd2;
        w_base = 8'h03;
      end
      default: begin
        w_size = 3'd4;
        w_base = 8'h0f;
      end
    endcase
    w_mask  = w_base << w_off;
    w_wd64  = {32'b0, w_wdata} << {w_off, 3'b000};
    w_legal = 1'b0;
    unique case (w_f3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~w_we;
      default:                w_legal = 1'b0;
    endcase
    w_misal = ((w_size == 3'd2) && w_off[0]) ||
              ((w_size == 3'd4) && (w_off != 2'b00));
    w_err   = ~w_legal || (!ALLOW_MISALIGNED && w_misal);
    w_cross = (({1'b0, w_off}) + w_size) > 3'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_f3     <= 3'b0;
      r_off    <= 2'b0;
      r_wdata  <= 32'b0;
      r_lo     <= 32'b0;
      r_rvalid <= 1'b0;
      r_rerr   <= 1'b0;
      r_rdata  <= 32'b0;
      r_mem_we <= 1'b0;
      r_mem_be <= 4'b0;
      r_mem_a  <= 32'b0;
      r_mem_wd <= 32'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_rerr   <= 1'b0;
      r_rdata  <= 32'b0;
      r_mem_we <= 1'b0;
      r_mem_be <= 4'b0;
      r_mem_a  <= 32'b0;
      r_mem_wd <= 32'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_f3    <= req_funct3;
            r_off   <= req_addr[1:0];
            r_wdata <= req_wdata;
            if (w_err) begin
              r_state  <= S_RESP;
              r_rvalid <= 1'b1;
              r_rerr   <= 1'b1;
            end else begin
              r_state  <= S_ACC0;
              r_mem_we <= req_we;
              r_mem_be <= w_mask[3:0];
              r_mem_a  <= {req_addr[31:2], 2'b00};
              r_mem_wd <= w_wd64[31:0];
            end
          end
        end
        S_ACC0: begin
          r_lo <= mem_rd;
          if (w_cross) begin
            r_state  <= S_ACC1;
            r_mem_we <= r_we;
            r_mem_be <= w_mask[7:4];
            r_mem_a  <= r_mem_a + 32'd4;
            r_mem_wd <= w_wd64[63:32];
          end else begin
            r_state  <= S_RESP;
            r_rvalid <= 1'b1;
            r_rdata  <= r_we ? 32'b0 :
                        f_load(r_f3, r_off, {32'b0, mem_rd});
          end
        end
        S_ACC1: begin
          r_state  <= S_RESP;
          r_rvalid <= 1'b1;
          r_rdata  <= r_we ? 32'b0 :
                      f_load(r_f3, r_off, {mem_rd, r_lo});
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reset must suppress the write of an access cycle it interrupts.
  assign mem_we     = r_mem_we & ~rst;
  assign mem_be     = r_mem_be;
  assign mem_a      = r_mem_a;
  assign mem_wd     = r_mem_wd;
  assign req_ready  = w_idle;
  assign resp_valid = r_rvalid;
  assign resp_err   = r_rerr;
  assign resp_rdata = r_rdata;

endmodule
